intersection_phase_scheduler: RTL and testbench

Four-approach intersection phase scheduler that sequences green/yellow/all-red phases and shares the single green right-of-way between four roads.
- Grants are round-robin over the per-road vehicle detectors.
- Green time is bounded by a minimum and a maximum, with gap-out when the served road's detector drops.
- An emergency preempt input forces a safe yellow/all-red sequence, then holds green on the emergency road.
- Runs on the 1 Hz system tick clock (1 cycle = 1 s). Its lights/state/counter outputs sit alongside the existing single-intersection controller.

---
 rtl/tlc_pkg.sv | 37 +++
 rtl/rr_pick4.sv | 26 ++
 rtl/intersection_phase_scheduler.sv | 169 ++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the intersection phase scheduler.
// Holds phase state encodings, per-road light codes and the light decoder.
package tlc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        CLEAR  = 3'd3,
        EMG    = 3'd4
    } state_t;

    localparam logic [2:0]  RED       = 3'b100;
    localparam logic [2:0]  YEL       = 3'b010;
    localparam logic [2:0]  GRN       = 3'b001;
    localparam int          NUM_ROADS = 4;
    localparam logic [11:0] ALL_RED   = 12'h924;

    // Only the active road may show a non-red aspect.
    function automatic logic [11:0] decode_lights(
        input state_t     s,
        input logic [1:0] road
    );
        logic [11:0] l;
        logic [2:0]  c;
        l = ALL_RED;
        unique case (s)
            GREEN,
            EMG:     c = GRN;
            YELLOW:  c = YEL;
            default: c = RED;
        endcase
        l[road*3 +: 3] = c;
        return l;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first set req bit after 'last'.
// Ports: req (requests), last (last served) -> grant (index), any (request seen).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] w_idx;

    // Scan last+1 .. last+4; the final step revisits 'last' itself.
    always_comb begin
        grant = last;
        any   = 1'b0;
        w_idx = last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = last + 2'(k);
            if (!any && req[w_idx]) begin
                grant = w_idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-approach green/yellow/all-red phase scheduler with emergency preempt.
// Ports: clk (1 Hz tick), rst (async active-low), vehicle_detect[3:0],
//   emg_req, emg_road[1:0] -> lights[11:0], active_road[1:0], state[2:0],
//   counter[CNT_W-1:0], emg_ack.
import tlc_pkg::*;

module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       vehicle_detect,
    input  logic             emg_req,
    input  logic [1:0]       emg_road,
    output logic [11:0]      lights,
    output logic [1:0]       active_road,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] counter,
    output logic             emg_ack
);

    localparam int ROAD_W = $clog2(NUM_ROADS);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_M1  = CNT_W'(ALLRED_T - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_counter;
    logic [ROAD_W-1:0]   r_active;
    logic [ROAD_W-1:0]   r_last;
    logic [ROAD_W-1:0]   r_emg_road;
    logic                r_pend;
    logic                r_emg_ack;

    logic [ROAD_W-1:0]   w_grant;
    logic                w_any;
    logic                w_other;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [ROAD_W-1:0]   w_emg_tgt;

    rr_pick4 u_pick (
        .req   (vehicle_detect),
        .last  (r_last),
        .grant (w_grant),
        .any   (w_any)
    );

    // Saturation only matters in IDLE/EMG; timed phases end well below it.
    assign w_cnt_inc = (r_counter == CNT_MAX) ? r_counter
                                              : r_counter + 1'b1;

    assign w_other = |(vehicle_detect & ~(4'b0001 << r_active));

    // A preempt honoured earlier keeps its latched road.
    assign w_emg_tgt = r_pend ? r_emg_road : emg_road;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_counter  <= '0;
            r_active   <= '0;
            r_last     <= 2'd3;
            r_emg_road <= '0;
            r_pend     <= 1'b0;
            r_emg_ack  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (emg_req) begin
                        r_state    <= EMG;
                        r_counter  <= '0;
                        r_active   <= emg_road;
                        r_emg_road <= emg_road;
                        r_emg_ack  <= 1'b1;
                    end else if (w_any) begin
                        r_state   <= GREEN;
                        r_counter <= '0;
                        r_active  <= w_grant;
                        r_last    <= w_grant;
                    end else begin
                        r_counter <= w_cnt_inc;
                    end
                end
                GREEN: begin
                    if (emg_req && emg_road == r_active) begin
                        r_state    <= EMG;
                        r_counter  <= '0;
                        r_emg_road <= emg_road;
                        r_emg_ack  <= 1'b1;
                    end else if (emg_req) begin
                        r_state    <= YELLOW;
                        r_counter  <= '0;
                        r_pend     <= 1'b1;
                        r_emg_road <= emg_road;
                    end else if (r_counter >= GMIN_M1 &&
                                 (w_other ||
                                  !vehicle_detect[r_active] ||
                                  r_counter == GMAX_M1)) begin
                        r_state   <= YELLOW;
                        r_counter <= '0;
                    end else begin
                        r_counter <= w_cnt_inc;
                    end
                end
                YELLOW: begin
                    if (emg_req && !r_pend) begin
                        r_pend     <= 1'b1;
                        r_emg_road <= emg_road;
                    end
                    if (r_counter == YEL_M1) begin
                        r_state   <= CLEAR;
                        r_counter <= '0;
                    end else begin
                        r_counter <= w_cnt_inc;
                    end
                end
                CLEAR: begin
                    if (r_counter == ARED_M1) begin
                        r_counter <= '0;
                        if (r_pend || emg_req) begin
                            r_state    <= EMG;
                            r_active   <= w_emg_tgt;
                            r_emg_road <= w_emg_tgt;
                            r_emg_ack  <= 1'b1;
                        end else if (w_any) begin
                            r_state  <= GREEN;
                            r_active <= w_grant;
                            r_last   <= w_grant;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_counter <= w_cnt_inc;
                    end
                end
                EMG: begin
                    if (!emg_req) begin
                        r_state   <= YELLOW;
                        r_counter <= '0;
                        r_active  <= r_emg_road;
                        r_last    <= r_emg_road;
                        r_pend    <= 1'b0;
                        r_emg_ack <= 1'b0;
                    end else begin
                        r_counter <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_counter <= '0;
                end
            endcase
        end
    end

    assign lights      = decode_lights(r_state, r_active);
    assign active_road = r_active;
    assign state       = r_state;
    assign counter     = r_counter;
    assign emg_ack     = r_emg_ack;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed scoreboard bench for intersection_phase_scheduler.
// Expected snapshots are queued per step and popped at each sample point.
module tb_intersection_phase_scheduler;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GRN  = 3'd1;
    localparam logic [2:0] S_YEL  = 3'd2;
    localparam logic [2:0] S_CLR  = 3'd3;
    localparam logic [2:0] S_EMG  = 3'd4;

    logic        clk;
    logic        rst;
    logic [3:0]  vehicle_detect;
    logic        emg_req;
    logic [1:0]  emg_road;
    logic [11:0] lights;
    logic [1:0]  active_road;
    logic [2:0]  state;
    logic [5:0]  counter;
    logic        emg_ack;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [23:0] v;
    } exp_t;

    exp_t sb[$];

    intersection_phase_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .vehicle_detect (vehicle_detect),
        .emg_req        (emg_req),
        .emg_road       (emg_road),
        .lights         (lights),
        .active_road    (active_road),
        .state          (state),
        .counter        (counter),
        .emg_ack        (emg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] lt(logic [2:0] st, logic [1:0] r);
        logic [11:0] l;
        l = 12'h924;
        if (st == S_GRN || st == S_EMG) l[r*3 +: 3] = 3'b001;
        else if (st == S_YEL)           l[r*3 +: 3] = 3'b010;
        return l;
    endfunction

    task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, {state, active_road, lights, counter, emg_ack}, e.v);
    endtask

    // One sample per cycle; counter expected from 'start', clamped at 63.
    task automatic phase(string tag, logic [2:0] st, logic [1:0] r,
                         int start, int n, logic ack);
        exp_t e;
        int   c;
        for (int i = 0; i < n; i++) begin
            c = (start + i > 63) ? 63 : start + i;
            e.tag = $sformatf("%s[%0d]", tag, start + i);
            e.v   = {st, r, lt(st, r), 6'(c), ack};
            sb.push_back(e);
            @(negedge clk);
            pop_check();
        end
    endtask

    initial begin
        rst            = 1'b0;
        vehicle_detect = 4'b0000;
        emg_req        = 1'b0;
        emg_road       = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_snapshot", {state, active_road, lights, counter, emg_ack},
            {S_IDLE, 2'd0, 12'h924, 6'd0, 1'b0});

        // Single requester: max-out, then re-served.
        rst            = 1'b1;
        vehicle_detect = 4'b0100;
        phase("g2", S_GRN, 2'd2, 0, 1, 1'b0);
        chk("lights_g2", {12'd0, lights}, {12'd0, 12'h864});
        phase("g2", S_GRN, 2'd2, 1, 29, 1'b0);
        phase("y2", S_YEL, 2'd2, 0, 1, 1'b0);
        chk("lights_y2", {12'd0, lights}, {12'd0, 12'h8A4});
        phase("y2", S_YEL, 2'd2, 1, 2, 1'b0);
        phase("c2", S_CLR, 2'd2, 0, 2, 1'b0);
        phase("g2b", S_GRN, 2'd2, 0, 3, 1'b0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_lights", {12'd0, lights}, {12'd0, 12'h924});
        chk("arst_state", {21'd0, state}, {21'd0, S_IDLE});
        chk("arst_cnt", {18'd0, counter}, 24'd0);
        chk("arst_ack", {23'd0, emg_ack}, 24'd0);
        @(negedge clk);

        // All roads requesting: strict rotation, minimum greens.
        rst            = 1'b1;
        vehicle_detect = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            phase("rr_g", S_GRN, 2'(r), 0, 10, 1'b0);
            phase("rr_y", S_YEL, 2'(r), 0, 3, 1'b0);
            phase("rr_c", S_CLR, 2'(r), 0, 2, 1'b0);
        end
        phase("rr_g0", S_GRN, 2'd0, 0, 1, 1'b0);

        // Gap-out on road 1 after the minimum.
        rst = 1'b0;
        @(negedge clk);
        rst            = 1'b1;
        vehicle_detect = 4'b0010;
        phase("gap_g", S_GRN, 2'd1, 0, 16, 1'b0);
        vehicle_detect = 4'b0000;
        phase("gap_y", S_YEL, 2'd1, 0, 3, 1'b0);
        phase("gap_c", S_CLR, 2'd1, 0, 2, 1'b0);
        phase("gap_i", S_IDLE, 2'd1, 0, 2, 1'b0);

        // Early drop: minimum green still enforced.
        vehicle_detect = 4'b0010;
        phase("min_g", S_GRN, 2'd1, 0, 4, 1'b0);
        vehicle_detect = 4'b0000;
        phase("min_g", S_GRN, 2'd1, 4, 6, 1'b0);
        phase("min_y", S_YEL, 2'd1, 0, 3, 1'b0);
        phase("min_c", S_CLR, 2'd1, 0, 2, 1'b0);
        phase("min_i", S_IDLE, 2'd1, 0, 1, 1'b0);

        // Preempt for another road during green.
        rst = 1'b0;
        @(negedge clk);
        rst            = 1'b1;
        vehicle_detect = 4'b0001;
        phase("pe_g0", S_GRN, 2'd0, 0, 5, 1'b0);
        emg_req  = 1'b1;
        emg_road = 2'd2;
        phase("pe_y0", S_YEL, 2'd0, 0, 3, 1'b0);
        phase("pe_c0", S_CLR, 2'd0, 0, 2, 1'b0);
        phase("pe_e2", S_EMG, 2'd2, 0, 3, 1'b1);
        emg_road = 2'd1;
        phase("pe_e2", S_EMG, 2'd2, 3, 3, 1'b1);
        emg_req        = 1'b0;
        vehicle_detect = 4'b1001;
        phase("pe_y2", S_YEL, 2'd2, 0, 3, 1'b0);
        phase("pe_c2", S_CLR, 2'd2, 0, 2, 1'b0);
        phase("pe_g3", S_GRN, 2'd3, 0, 1, 1'b0);

        // Preempt for the green road: no yellow, counter saturates.
        emg_req  = 1'b1;
        emg_road = 2'd3;
        phase("em_e3", S_EMG, 2'd3, 0, 70, 1'b1);
        emg_req = 1'b0;
        phase("em_y3", S_YEL, 2'd3, 0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
